// File: rtl/data_memory_initiator_if.sv
// data_memory_initiator_if
//   Groups the request/response handshake with the execute/memory stage and
//   the control half of the data memory bus.
//
//   The shared 32-bit data bus is not part of this interface. It is a
//   tri-state net, so it stays a plain inout port on the initiator, where the
//   driver and the resolution are visible at the module boundary.
//
//   Handshake: a request transfers on a rising CLK edge where req_valid and
//   req_ready are both 1. All req_* fields must be stable while req_valid is
//   high. resp_valid is a single-cycle pulse with no back-pressure.
//   resp_error and resp_load_data mean something only while resp_valid is 1.
//
//   Modports:
//     master : the initiator. It consumes requests and drives the responses
//              and the bus control signals.
//     slave  : the surrounding system, meaning the requester and the memory
//              responder.
interface data_memory_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_store_data;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_load_data;
  logic        data_memory_interface_enable;
  logic        data_memory_interface_state;
  logic [31:0] data_memory_interface_address;
  logic [3:0]  data_memory_interface_frame_mask;

  modport master (
    input  req_valid, req_write, req_funct3, req_address, req_store_data,
    output req_ready, resp_valid, resp_error, resp_load_data,
    output data_memory_interface_enable, data_memory_interface_state,
    output data_memory_interface_address, data_memory_interface_frame_mask
  );

  modport slave (
    output req_valid, req_write, req_funct3, req_address, req_store_data,
    input  req_ready, resp_valid, resp_error, resp_load_data,
    input  data_memory_interface_enable, data_memory_interface_state,
    input  data_memory_interface_address, data_memory_interface_frame_mask
  );
endinterface

// File: rtl/data_memory_initiator.sv
// data_memory_initiator
//   Bus initiator for the data memory. Each load or store request from the
//   execute/memory stage becomes one bus transaction. The block handles RV32I
//   byte and halfword lane selection, replicates store data across lanes, and
//   sign- or zero-extends load results.
//
// Parameters
//   READ_LATENCY : cycles from the ISSUE sampling edge until the responder's
//                  read data is valid. Must be 1 or more.
//
// Ports
//   CLK                        clock; all logic runs on the rising edge
//   reset                      synchronous, active-high
//   bus (master modport)       request/response handshake and bus control
//                              (enable, state, address, frame_mask)
//   data_memory_interface_data shared tri-state data bus. It is driven only
//                              during ISSUE of a store.
//   dbg_state                  current FSM state: 0 IDLE, 1 ISSUE, 2 WAIT,
//                              3 RESPOND
//
// Optional feature macro: MEMORY_INTERFACE_MISALIGN_TRAP_EN
//   When defined, a misaligned halfword or word access is rejected with
//   resp_error and no bus cycle is started. When undefined, the offending low
//   address bits are ignored.
//
// FSM: IDLE -> ISSUE -> WAIT (READ_LATENCY cycles) -> RESPOND -> IDLE for
//      loads; IDLE -> ISSUE -> RESPOND for stores; IDLE -> RESPOND for
//      rejected requests.
module data_memory_initiator #(
  parameter int READ_LATENCY = 1
) (
  input  logic                           CLK,
  input  logic                           reset,
  data_memory_initiator_if.master        bus,
  inout  wire  [31:0]                    data_memory_interface_data,
  output logic [1:0]                     dbg_state
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_RESPOND = 2'd3;
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  logic [1:0]    state_q;
  logic          write_q;
  logic [2:0]    funct3_q;
  logic [31:0]   addr_q;
  logic [31:0]   sdata_q;
  logic          err_q;
  logic [31:0]   load_q;
  logic [CW-1:0] wait_cnt;

  logic          req_legal;
  logic          wait_last;
  logic          issue;
  logic [1:0]    lane;
  logic [3:0]    mask;
  logic [31:0]   store_bus;
  logic [31:0]   load_ext;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;

  // The request is legal only if its funct3 is a defined load or store
  // encoding. With the trap macro, a misaligned access is also illegal.
  always_comb begin
    req_legal = 1'b0;
    if (bus.req_write) begin
      req_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                  (bus.req_funct3 == 3'b010);
    end else begin
      req_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                  (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                  (bus.req_funct3 == 3'b101);
    end
`ifdef MEMORY_INTERFACE_MISALIGN_TRAP_EN
    if ((bus.req_funct3[1:0] == 2'b01) && bus.req_address[0])
      req_legal = 1'b0;
    if ((bus.req_funct3[1:0] == 2'b10) && (bus.req_address[1:0] != 2'b00))
      req_legal = 1'b0;
`endif
  end

  // Lane k holds bus bits 8k+7:8k, and frame_mask bit (3-k) enables lane k.
  // A halfword uses only addr[1], and a word always covers all four lanes.
  // That is how an untrapped misaligned access ignores its low address bits.
  always_comb begin
    lane      = addr_q[1:0];
    mask      = 4'b0000;
    store_bus = 32'h0;
    load_ext  = 32'h0;
    sel_byte  = 8'h0;
    sel_half  = 16'h0;
    case (lane)
      2'd0:    sel_byte = data_memory_interface_data[7:0];
      2'd1:    sel_byte = data_memory_interface_data[15:8];
      2'd2:    sel_byte = data_memory_interface_data[23:16];
      default: sel_byte = data_memory_interface_data[31:24];
    endcase
    sel_half = lane[1] ? data_memory_interface_data[31:16]
                       : data_memory_interface_data[15:0];
    case (funct3_q[1:0])
      2'b00: begin
        mask      = 4'b1000 >> lane;
        store_bus = {4{sdata_q[7:0]}};
        load_ext  = funct3_q[2] ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      end
      2'b01: begin
        mask      = lane[1] ? 4'b0011 : 4'b1100;
        store_bus = {2{sdata_q[15:0]}};
        load_ext  = funct3_q[2] ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
      end
      default: begin
        mask      = 4'b1111;
        store_bus = sdata_q;
        load_ext  = data_memory_interface_data;
      end
    endcase
  end

  assign wait_last = (wait_cnt == CW'(READ_LATENCY - 1));

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      sdata_q  <= 32'h0;
      err_q    <= 1'b0;
      load_q   <= 32'h0;
      wait_cnt <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            write_q  <= bus.req_write;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_address;
            sdata_q  <= bus.req_store_data;
            // Clearing the result here ensures that stores and rejected
            // requests respond with zero data.
            load_q   <= 32'h0;
            wait_cnt <= '0;
            err_q    <= !req_legal;
            state_q  <= req_legal ? S_ISSUE : S_RESPOND;
          end
        end
        S_ISSUE: state_q <= write_q ? S_RESPOND : S_WAIT;
        S_WAIT: begin
          // The responder's read data is valid on the last WAIT edge.
          if (wait_last) begin
            load_q  <= load_ext;
            state_q <= S_RESPOND;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_RESPOND: state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  assign issue = (state_q == S_ISSUE);

  assign bus.req_ready                        = (state_q == S_IDLE);
  assign bus.resp_valid                       = (state_q == S_RESPOND);
  assign bus.resp_error                       = (state_q == S_RESPOND) && err_q;
  assign bus.resp_load_data                   = (state_q == S_RESPOND) ? load_q : 32'h0;
  assign bus.data_memory_interface_enable     = issue;
  assign bus.data_memory_interface_state      = issue && write_q;
  assign bus.data_memory_interface_address    = issue ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.data_memory_interface_frame_mask = issue ? mask : 4'b0000;
  assign data_memory_interface_data           = (issue && write_q) ? store_bus : 32'bz;
  assign dbg_state                            = state_q;
endmodule

// File: tb/tb_data_memory_initiator.sv
// tb_data_memory_initiator
//   Bench for data_memory_initiator with READ_LATENCY = 1. It includes a
//   behavioural memory responder with one-cycle read latency. When the bus is
//   not carrying store data, the responder parks it at 0 or drives read data.
//   Any stray drive from the initiator therefore shows up as a nonzero value.
module tb_data_memory_initiator;
  localparam int RL = 1;
`ifdef MEMORY_INTERFACE_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic        e_err;
    logic [31:0] e_data;
    logic [3:0]  e_mask;
    logic [31:0] e_bus;
  } vec_t;

  logic        CLK;
  logic        reset;
  wire  [31:0] data_bus;
  logic [1:0]  dbg_state;

  data_memory_initiator_if dm_if();

  data_memory_initiator #(.READ_LATENCY(RL)) dut (
    .CLK                        (CLK),
    .reset                      (reset),
    .bus                        (dm_if),
    .data_memory_interface_data (data_bus),
    .dbg_state                  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cycle_cnt = 0;
  always @(posedge CLK) cycle_cnt <= cycle_cnt + 1;

  // ---------------- memory responder ----------------
  logic        rd_pend;
  logic [31:0] rd_word;
  logic [31:0] mem [0:511];
  logic        tb_oe;
  logic [31:0] tb_val;

  assign tb_oe    = !(dm_if.data_memory_interface_enable && dm_if.data_memory_interface_state);
  assign tb_val   = rd_pend ? rd_word : 32'h0;
  assign data_bus = tb_oe ? tb_val : 32'bz;

  always @(posedge CLK) begin : responder
    logic [31:0] w;
    logic [8:0]  idx;
    idx = dm_if.data_memory_interface_address[10:2];
    rd_pend <= 1'b0;
    if (dm_if.data_memory_interface_enable) begin
      if (dm_if.data_memory_interface_state) begin
        w = mem[idx];
        for (int k = 0; k < 4; k++)
          if (dm_if.data_memory_interface_frame_mask[3-k]) w[8*k +: 8] = data_bus[8*k +: 8];
        mem[idx] <= w;
      end else begin
        rd_pend <= 1'b1;
        rd_word <= mem[idx];
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  int          due_q[$];
  int          checks = 0;
  int          errors = 0;
  int          en_cnt = 0;
  int          exp_en = 0;
  int          resp_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin : monitor
    logic [32:0] e;
    int          d;
    if (!reset) begin
      if (dm_if.data_memory_interface_enable) en_cnt++;
      if (dm_if.resp_valid) begin
        resp_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got resp_valid at cycle %0d expected none", cycle_cnt);
        end else begin
          e = exp_q.pop_front();
          d = due_q.pop_front();
          chk("resp_error", dm_if.resp_error, e[32]);
          chk("resp_load_data", dm_if.resp_load_data, e[31:0]);
          chk("resp_latency", cycle_cnt, d);
        end
      end else begin
        chk("resp_idle_zero", {dm_if.resp_error, dm_if.resp_load_data}, 33'h0);
        if (due_q.size() > 0 && cycle_cnt > due_q[0]) begin
          checks++;
          errors++;
          $display("FAIL resp_timeout: got no response by cycle %0d expected at %0d", cycle_cnt, due_q[0]);
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  function automatic vec_t mk(input logic w, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic e_err, input logic [31:0] e_data,
                              input logic [3:0] e_mask, input logic [31:0] e_bus);
    vec_t v;
    v.w = w; v.f3 = f3; v.a = a; v.sd = sd;
    v.e_err = e_err; v.e_data = e_data; v.e_mask = e_mask; v.e_bus = e_bus;
    return v;
  endfunction

  // Called #1 after a rising edge. Returns the cycle count of the accept edge.
  task automatic send(input vec_t v, output int acc);
    int guard;
    int lat;
    guard = 0;
    dm_if.req_valid      = 1'b1;
    dm_if.req_write      = v.w;
    dm_if.req_funct3     = v.f3;
    dm_if.req_address    = v.a;
    dm_if.req_store_data = v.w ? v.sd : $urandom_range(32'h0001_0000, 32'h7FFF_FFFF);
    while (!dm_if.req_ready && guard < 40) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (!dm_if.req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 40 cycles");
      dm_if.req_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge CLK); #1;
    acc = cycle_cnt;
    lat = v.e_err ? 1 : (v.w ? 2 : 2 + RL);
    exp_q.push_back({v.e_err, v.e_data});
    due_q.push_back(acc + lat - 1);
    dm_if.req_valid = 1'b0;
    if (v.e_err) begin
      chk("err_no_enable", dm_if.data_memory_interface_enable, 1'b0);
    end else begin
      exp_en++;
      chk("issue_enable", dm_if.data_memory_interface_enable, 1'b1);
      chk("issue_state", dm_if.data_memory_interface_state, v.w);
      chk("issue_address", dm_if.data_memory_interface_address, {v.a[31:2], 2'b00});
      chk("issue_mask", dm_if.data_memory_interface_frame_mask, v.e_mask);
      chk("issue_bus", data_bus, v.e_bus);
    end
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (!dm_if.req_ready && guard < 40) begin
      @(posedge CLK); #1;
      guard++;
    end
  endtask

  // ---------------- test ----------------
  localparam int NV = 23;

  initial begin
    vec_t        tab[NV];
    int          acc, a1, a2, a3, a4, base_resp, guard;
    logic [31:0] ra, rd;

    reset = 1'b1;
    dm_if.req_valid = 1'b0; dm_if.req_write = 1'b0; dm_if.req_funct3 = 3'b000;
    dm_if.req_address = 32'h0; dm_if.req_store_data = 32'h0;
    repeat (3) @(posedge CLK);
    #1 reset = 1'b0;

    chk("rst_req_ready", dm_if.req_ready, 1'b1);
    chk("rst_resp_valid", dm_if.resp_valid, 1'b0);
    chk("rst_resp_error", dm_if.resp_error, 1'b0);
    chk("rst_resp_data", dm_if.resp_load_data, 32'h0);
    chk("rst_enable", dm_if.data_memory_interface_enable, 1'b0);
    chk("rst_state", dm_if.data_memory_interface_state, 1'b0);
    chk("rst_address", dm_if.data_memory_interface_address, 32'h0);
    chk("rst_mask", dm_if.data_memory_interface_frame_mask, 4'h0);
    chk("rst_bus_free", data_bus, 32'h0);
    chk("rst_dbg_state", dbg_state, 2'd0);

    //            w  f3      addr          store         err   load data                          mask     bus
    tab[0]  = mk(1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0,                             4'b1111, 32'hDEADBEEF);
    tab[1]  = mk(0, 3'b010, 32'h100, 32'h0,        1'b0, 32'hDEADBEEF,                      4'b1111, 32'h0);
    tab[2]  = mk(1, 3'b000, 32'h103, 32'h000000A5, 1'b0, 32'h0,                             4'b0001, 32'hA5A5A5A5);
    tab[3]  = mk(0, 3'b000, 32'h103, 32'h0,        1'b0, 32'hFFFFFFA5,                      4'b0001, 32'h0);
    tab[4]  = mk(0, 3'b100, 32'h103, 32'h0,        1'b0, 32'h000000A5,                      4'b0001, 32'h0);
    tab[5]  = mk(1, 3'b001, 32'h102, 32'h00008001, 1'b0, 32'h0,                             4'b0011, 32'h80018001);
    tab[6]  = mk(0, 3'b001, 32'h102, 32'h0,        1'b0, 32'hFFFF8001,                      4'b0011, 32'h0);
    tab[7]  = mk(0, 3'b101, 32'h102, 32'h0,        1'b0, 32'h00008001,                      4'b0011, 32'h0);
    tab[8]  = mk(0, 3'b010, 32'h102, 32'h0,        TRAP, TRAP ? 32'h0 : 32'h8001BEEF,       4'b1111, 32'h0);
    tab[9]  = mk(0, 3'b011, 32'h100, 32'h0,        1'b1, 32'h0,                             4'b0000, 32'h0);
    tab[10] = mk(1, 3'b100, 32'h100, 32'h12345678, 1'b1, 32'h0,                             4'b0000, 32'h0);
    tab[11] = mk(0, 3'b000, 32'h100, 32'h0,        1'b0, 32'hFFFFFFEF,                      4'b1000, 32'h0);
    tab[12] = mk(0, 3'b100, 32'h101, 32'h0,        1'b0, 32'h000000BE,                      4'b0100, 32'h0);
    tab[13] = mk(0, 3'b001, 32'h100, 32'h0,        1'b0, 32'hFFFFBEEF,                      4'b1100, 32'h0);
    tab[14] = mk(1, 3'b000, 32'h101, 32'h1234567F, 1'b0, 32'h0,                             4'b0100, 32'h7F7F7F7F);
    tab[15] = mk(0, 3'b000, 32'h101, 32'h0,        1'b0, 32'h0000007F,                      4'b0100, 32'h0);
    tab[16] = mk(1, 3'b010, 32'h204, 32'h13579BDF, 1'b0, 32'h0,                             4'b1111, 32'h13579BDF);
    tab[17] = mk(0, 3'b010, 32'h204, 32'h0,        1'b0, 32'h13579BDF,                      4'b1111, 32'h0);
    tab[18] = mk(0, 3'b101, 32'h101, 32'h0,        TRAP, TRAP ? 32'h0 : 32'h00007FEF,       4'b1100, 32'h0);
    tab[19] = mk(1, 3'b001, 32'h103, 32'hFFFF1111, TRAP, 32'h0,                             4'b0011, 32'h11111111);
    tab[20] = mk(0, 3'b010, 32'h100, 32'h0,        1'b0, TRAP ? 32'h80017FEF : 32'h11117FEF, 4'b1111, 32'h0);
    tab[21] = mk(0, 3'b110, 32'h104, 32'h0,        1'b1, 32'h0,                             4'b0000, 32'h0);
    tab[22] = mk(1, 3'b011, 32'h104, 32'hCAFECAFE, 1'b1, 32'h0,                             4'b0000, 32'h0);

    for (int i = 0; i < NV; i++) send(tab[i], acc);

    // Back-to-back: req_valid stays high and each request is taken in the
    // IDLE cycle right after the previous RESPOND.
    send(mk(1, 3'b010, 32'h300, 32'hCAFEF00D, 1'b0, 32'h0, 4'b1111, 32'hCAFEF00D), a1);
    send(mk(1, 3'b010, 32'h304, 32'h0BADF00D, 1'b0, 32'h0, 4'b1111, 32'h0BADF00D), a2);
    send(mk(0, 3'b010, 32'h300, 32'h0, 1'b0, 32'hCAFEF00D, 4'b1111, 32'h0), a3);
    send(mk(0, 3'b010, 32'h304, 32'h0, 1'b0, 32'h0BADF00D, 4'b1111, 32'h0), a4);
    chk("b2b_store_store_gap", a2 - a1, 3);
    chk("b2b_store_load_gap", a3 - a2, 3);
    chk("b2b_load_load_gap", a4 - a3, 3 + RL);

    // Reset during WAIT abandons the load without a response.
    wait_ready();
    dm_if.req_valid = 1'b1; dm_if.req_write = 1'b0; dm_if.req_funct3 = 3'b010;
    dm_if.req_address = 32'h204; dm_if.req_store_data = 32'h0;
    @(posedge CLK); #1;
    dm_if.req_valid = 1'b0;
    exp_en++;
    chk("abort_in_issue", dbg_state, 2'd1);
    @(posedge CLK); #1;
    chk("abort_in_wait", dbg_state, 2'd2);
    reset = 1'b1;
    base_resp = resp_cnt;
    @(posedge CLK); #1;
    reset = 1'b0;
    chk("abort_req_ready", dm_if.req_ready, 1'b1);
    chk("abort_resp_valid", dm_if.resp_valid, 1'b0);
    chk("abort_enable", dm_if.data_memory_interface_enable, 1'b0);
    chk("abort_address", dm_if.data_memory_interface_address, 32'h0);
    chk("abort_mask", dm_if.data_memory_interface_frame_mask, 4'h0);
    chk("abort_bus_free", data_bus, 32'h0);
    chk("abort_dbg_state", dbg_state, 2'd0);
    repeat (4) @(posedge CLK);
    #1;
    chk("abort_no_resp", resp_cnt, base_resp);
    send(mk(0, 3'b010, 32'h204, 32'h0, 1'b0, 32'h13579BDF, 4'b1111, 32'h0), acc);

    // Random word store/load pairs in a region the table does not touch.
    for (int i = 0; i < 6; i++) begin
      ra = 32'h400 + {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      rd = $urandom();
      send(mk(1, 3'b010, ra, rd, 1'b0, 32'h0, 4'b1111, rd), acc);
      send(mk(0, 3'b010, ra, 32'h0, 1'b0, rd, 4'b1111, 32'h0), acc);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin
      @(posedge CLK); #1;
      guard++;
    end
    chk("drain_pending", exp_q.size(), 0);
    @(posedge CLK); #1;
    chk("final_bus_free", data_bus, 32'h0);
    chk("enable_pulses", en_cnt, exp_en);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
